// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if
//   Valid/ready payload bus used on both sides of pipe_stage_skid.
//   Ports (signals):
//     valid - producer holds a payload this cycle
//     ready - consumer can take the payload this cycle
//     data  - DATA_W-bit payload (control + data fields concatenated)
//   Modports:
//     master - producer side (drives valid/data, samples ready)
//     slave  - consumer side (samples valid/data, drives ready)
interface pipe_stage_skid_if #(
  parameter int DATA_W = 96
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic pipeline stage register with a valid/ready handshake and a
//   2-entry skid buffer.  in_ready (up.ready) is a pure function of the state
//   register, so no combinational ready path crosses the stage, yet full
//   throughput is kept under back-pressure.  flush inserts a bubble.
//   Optional feature macro: STAGE_PERF_EN (stall/kill performance counters).
//
//   Ports:
//     clk        in   clock, all state updates on posedge
//     rst        in   synchronous active-high reset
//     flush      in   synchronous kill of all held entries (below rst)
//     up         slave  modport: in_valid / in_ready / in_data
//     dn         master modport: out_valid / out_ready / out_data
//     stall_cnt  out  CNT_W, cycles with out_valid & ~out_ready (STAGE_PERF_EN)
//     kill_cnt   out  CNT_W, valid entries discarded by flush  (STAGE_PERF_EN)
module pipe_stage_skid #(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
`ifdef STAGE_PERF_EN
  ,
  parameter int                CNT_W      = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  pipe_stage_skid_if.slave   up,
  pipe_stage_skid_if.master  dn
`ifdef STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   kill_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready;
  logic              out_valid;
  logic              acc;
  logic              take;

  assign acc  = up.valid & in_ready;
  assign take = out_valid & dn.ready;

  // State and payload registers; rst wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and payload movement.  The skid entry only ever refills main,
  // so FIFO order is preserved.  flush overrides the handshake result, which
  // discards any same-cycle accept.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          main_d  = up.data;
        end
      end
      ONE: begin
        if (acc && take) begin
          main_d = up.data;
        end else if (acc) begin
          state_d = FULL;
          skid_d  = up.data;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end
  end

  // Outputs depend only on registered state.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
  end

  assign up.ready = in_ready;
  assign dn.valid = out_valid;
  assign dn.data  = main_q;

`ifdef STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] kill_q;
  logic [1:0]       kill_inc;
  logic [CNT_W:0]   kill_sum;

  // Entries lost to flush; an entry taken downstream in the same cycle was
  // delivered, so it does not count as killed.
  always_comb begin
    kill_inc = 2'd0;
    if (flush) begin
      unique case (state_q)
        ONE:     kill_inc = take ? 2'd0 : 2'd1;
        FULL:    kill_inc = take ? 2'd1 : 2'd2;
        default: kill_inc = 2'd0;
      endcase
    end
    kill_sum = {1'b0, kill_q} + {{(CNT_W-1){1'b0}}, kill_inc};
  end

  // Saturating counters, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      kill_q  <= '0;
    end else begin
      if (out_valid && !dn.ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      kill_q <= kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    end
  end

  assign stall_cnt = stall_q;
  assign kill_cnt  = kill_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Directed bench for pipe_stage_skid: streaming, skid under back-pressure,
//   flush while FULL, flush with same-cycle accept, reset mid-operation and
//   (with STAGE_PERF_EN) counter saturation at CNT_W=4.
module tb_pipe_stage_skid;

  localparam int DATA_W = 16;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  int vectors   = 0;
  int miscomps  = 0;

  pipe_stage_skid_if #(.DATA_W(DATA_W)) upIf ();
  pipe_stage_skid_if #(.DATA_W(DATA_W)) dnIf ();

`ifdef STAGE_PERF_EN
  logic [3:0] stall_cnt;
  logic [3:0] kill_cnt;
`endif

  pipe_stage_skid #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL ({DATA_W{1'b0}})
`ifdef STAGE_PERF_EN
    ,
    .CNT_W      (4)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (upIf.slave),
    .dn        (dnIf.master)
`ifdef STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .kill_cnt  (kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance past the edge, settle for sampling.
  task automatic applyStimulus(input logic rstV, input logic flushV,
                               input logic inValid, input logic [15:0] inData,
                               input logic outReady);
    rst         = rstV;
    flush       = flushV;
    upIf.valid  = inValid;
    upIf.data   = inData;
    dnIf.ready  = outReady;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscomps++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic expValid,
                            input logic expReady, input logic [15:0] expData);
    checkOutput({tag, ".out_valid"}, {31'd0, dnIf.valid}, {31'd0, expValid});
    checkOutput({tag, ".in_ready"},  {31'd0, upIf.ready}, {31'd0, expReady});
    checkOutput({tag, ".out_data"},  {16'd0, dnIf.data},  {16'd0, expData});
  endtask

  initial begin
    upIf.valid = 1'b0;
    upIf.data  = '0;
    dnIf.ready = 1'b0;

    // 1. Reset then stream
    applyStimulus(1, 0, 0, 16'h0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0);
    checkState("reset", 0, 1, 16'h0000);
`ifdef STAGE_PERF_EN
    checkOutput("reset.stall_cnt", {28'd0, stall_cnt}, 32'd0);
    checkOutput("reset.kill_cnt",  {28'd0, kill_cnt},  32'd0);
`endif
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 1, 16'(i), 1);
      checkState($sformatf("stream%0d", i), 1, 1, 16'(i));
    end
    applyStimulus(0, 0, 0, 16'h0, 1);
    checkOutput("stream.drain.out_valid", {31'd0, dnIf.valid}, 32'd0);

    // 2. Back-pressure skid
    applyStimulus(0, 0, 1, 16'h000A, 1);
    checkState("skid.loadA", 1, 1, 16'h000A);
    applyStimulus(0, 0, 1, 16'h000B, 0);
    checkState("skid.full", 1, 0, 16'h000A);
    applyStimulus(0, 0, 0, 16'h0, 1);
    checkState("skid.takeA", 1, 1, 16'h000B);
    applyStimulus(0, 0, 0, 16'h0, 1);
    checkOutput("skid.takeB.out_valid", {31'd0, dnIf.valid}, 32'd0);

    // 3. Flush while FULL
    applyStimulus(0, 0, 1, 16'h000A, 0);
    applyStimulus(0, 0, 1, 16'h000B, 0);
    checkState("flushfull.pre", 1, 0, 16'h000A);
    applyStimulus(0, 1, 0, 16'h0, 0);
    checkState("flushfull", 0, 1, 16'h0000);
`ifdef STAGE_PERF_EN
    checkOutput("flushfull.kill_cnt",  {28'd0, kill_cnt},  32'd2);
    checkOutput("flushfull.stall_cnt", {28'd0, stall_cnt}, 32'd3);
`endif

    // 4. Flush with same-cycle accept
    applyStimulus(0, 0, 1, 16'h0005, 0);
    checkState("flushacc.pre", 1, 1, 16'h0005);
    applyStimulus(0, 1, 1, 16'h0006, 0);
    checkState("flushacc", 0, 1, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0, 0);
    checkState("flushacc.after", 0, 1, 16'h0000);
`ifdef STAGE_PERF_EN
    checkOutput("flushacc.kill_cnt", {28'd0, kill_cnt}, 32'd3);
`endif

    // 5. Reset mid-operation (fresh reset so stall_cnt counts from zero)
    applyStimulus(1, 0, 0, 16'h0, 0);
    applyStimulus(0, 0, 1, 16'h0011, 0);
    applyStimulus(0, 0, 1, 16'h0022, 0);
    applyStimulus(0, 0, 0, 16'h0, 0);
    applyStimulus(0, 0, 0, 16'h0, 0);
    checkState("midreset.pre", 1, 0, 16'h0011);
`ifdef STAGE_PERF_EN
    checkOutput("midreset.pre.stall_cnt", {28'd0, stall_cnt}, 32'd3);
`endif
    applyStimulus(1, 0, 0, 16'h0, 0);
    checkState("midreset", 0, 1, 16'h0000);
`ifdef STAGE_PERF_EN
    checkOutput("midreset.stall_cnt", {28'd0, stall_cnt}, 32'd0);
`endif

    // 6. Counter saturation: one entry held with out_ready=0 for 20 cycles
    applyStimulus(0, 0, 1, 16'h0033, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 16'h0, 0);
    end
    checkState("saturate", 1, 1, 16'h0033);
`ifdef STAGE_PERF_EN
    checkOutput("saturate.stall_cnt", {28'd0, stall_cnt}, 32'd15);
`endif
    applyStimulus(0, 0, 0, 16'h0, 1);
    checkOutput("saturate.drain.out_valid", {31'd0, dnIf.valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field pipeline stage registers (IF/ID, ID/EX, EX/MEM).
- One generic DATA_W payload register, with a full valid/ready handshake replacing the bare `lock` input.
- A 2-entry skid buffer keeps full throughput under back-pressure with registered in_ready, so no combinational ready path runs through the stage.
- `flush` inserts a bubble.
- Instantiated between any two pipeline stages; the control and data buses are concatenated into data.

Parameters:
DATA_W, 96, payload width in bits (control + data fields concatenated by the instantiating stage)
BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data after reset or flush (all-zero = NOP control)
CNT_W, 16, width of the performance counters (used only with STAGE_PERF_EN)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of all held entries; priority below rst, above all else
in_valid  in  1  upstream has a payload
in_ready  out  1  stage can accept; registered, depends only on state
in_data  in  DATA_W  upstream payload
out_valid  out  1  out_data holds a valid payload
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  payload, driven directly from the main register
stall_cnt  out  CNT_W  only with STAGE_PERF_EN
kill_cnt  out  CNT_W  only with STAGE_PERF_EN

Behaviour:
- Storage: main register (drives out_data) and skid register, each with a valid bit.
- Handshake events:
  - acc = in_valid & in_ready
  - take = out_valid & out_ready
- States: EMPTY (none valid), ONE (main valid), FULL (main + skid valid).
- Outputs per state:
  - out_valid = state != EMPTY
  - in_ready = state != FULL
- Transitions (no rst, no flush):
  - EMPTY: acc -> ONE, main <= in_data; else stay EMPTY.
  - ONE: acc & take -> ONE, main <= in_data. acc only -> FULL, skid <= in_data. take only -> EMPTY. Neither -> hold.
  - FULL: take -> ONE, main <= skid. No acc is possible (in_ready=0). Otherwise hold.
- Latency: 1 cycle, in_data accepted at edge N appears on out_data after edge N.
- Throughput: 1 payload/cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry never overtakes main.
- When EMPTY without flush/rst, out_data holds the last value (don't-care, since out_valid=0).
- rst=1 at posedge:
  - state EMPTY, out_valid=0, in_ready=1, out_data=BUBBLE_VAL
  - skid cleared to BUBBLE_VAL
  - counters 0
  - applies mid-operation; any in-flight payload is lost.
- flush=1 at posedge (rst=0):
  - state EMPTY, out_data=BUBBLE_VAL, skid=BUBBLE_VAL.
  - A payload handshaked (acc) in the same cycle is discarded.
  - A same-cycle take still completes downstream (downstream saw out_valid=1); flushing the source stage is the caller's responsibility.
- flush and out_ready=0 with FULL: both entries dropped.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: STAGE_PERF_EN.
- When defined:
  - stall_cnt increments each cycle out_valid & ~out_ready.
  - kill_cnt increments by the number of valid entries (0, 1 or 2) discarded by flush.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - Both are cleared only by rst; flush does not clear them.
- When undefined: stall_cnt, kill_cnt ports and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset then stream:
   - Stimulus: rst 2 cycles; then in_valid=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles.
   - Response: out_data 1,2,3,4 one cycle later, out_valid=1 every cycle, in_ready=1 throughout.
2. Back-pressure skid:
   - Stimulus: send 0xA; next cycle out_ready=0 while sending 0xB.
   - Response: state FULL, in_ready=0, out_data=0xA held.
   - Stimulus: then out_ready=1.
   - Response: 0xA, then 0xB out; in_ready returns to 1 one cycle after the 0xA take.
3. Flush while FULL:
   - Stimulus: hold 0xA/0xB with out_ready=0; assert flush 1 cycle.
   - Response: out_valid=0, out_data=BUBBLE_VAL=0, in_ready=1; kill_cnt=2 (PERF_EN).
4. Flush with same-cycle accept:
   - Stimulus: ONE with 0x5, in_valid=1 data 0x6, flush=1, out_ready=0.
   - Response: next cycle EMPTY; 0x6 never appears on out_data.
5. Reset mid-operation:
   - Stimulus: FULL with out_ready=0; stall_cnt=3; rst 1 cycle.
   - Response: out_valid=0, in_ready=1, out_data=0, stall_cnt=0.
6. Counter saturation:
   - Stimulus: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles.
   - Response: stall_cnt reaches 15 and holds.
